axi4l_regfile_slave: RTL
========================

# axi4l_regfile_slave

AXI4-Lite responder terminating one slave port of the AXI4-Lite interconnect. Holds a bank of NUM_REGS memory-mapped control/status registers with byte-strobe writes, independent read and write channels, and SLVERR for out-of-range accesses. Register contents are exported flat to the surrounding hardware.

## Interface
- DATA_SIZE, 32, data bus width in bits; multiple of 8.
- ADDR_SIZE, 10, address width as delivered by the interconnect.
- NUM_REGS, 16, number of DATA_SIZE-bit registers; 1 ≤ NUM_REGS ≤ 2^(ADDR_SIZE-2).
- slv.ACLK  input  1  single clock; all logic on rising edge.
- slv.ARESETn  input  1  reset, asynchronous assert, active-low.
- slv  axi4_lite_if  n/a  slave modport: aw*, w*, b*, ar*, r* channels.
- regs_o  output  NUM_REGS*DATA_SIZE  current register contents; register k at bits [k*DATA_SIZE +: DATA_SIZE].

## Operation
- Word addressing: index = addr[ADDR_SIZE-1:2]; addr[1:0] ignored. index ≥ NUM_REGS is out of range.
- Write FSM, states WR_IDLE and WR_RESP:
  - WR_IDLE: awready = !aw_held, wready = !w_held. AW and W are accepted independently and in either order, each latched into its own holding register.
  - The write commits when both are held, or on the cycle the second handshake completes. The FSM then goes to WR_RESP.
  - Commit rule: byte lane j of reg[index] is updated iff wstrb[j]=1 and the access is legal. wstrb=0 leaves the register unchanged and still returns OKAY.
  - WR_RESP: bvalid=1, awready=wready=0. bresp is OKAY, or SLVERR for out-of-range (register left unchanged). On bvalid&&bready the FSM returns to WR_IDLE and clears aw_held and w_held.
- Read FSM, states RD_IDLE and RD_RESP:
  - RD_IDLE: arready=1. On arvalid, rdata is registered from reg[index] (0 if out of range) and the FSM goes to RD_RESP.
  - RD_RESP: arready=0, rvalid=1. rdata and rresp are held stable until rready. rresp is OKAY, or SLVERR for out-of-range. On rvalid&&rready the FSM returns to RD_IDLE.
- At most one outstanding transaction per direction. The read and write FSMs are fully independent.
- Simultaneous read of a register and write commit on that same register in one edge: read returns the pre-write value.
- bresp/rresp encodings are taken from the shared package.

## Timing
- Reset values:
  - awready, wready, arready, bvalid, rvalid = 0 while ARESETn is low.
  - bresp, rresp = OKAY; rdata = 0; all registers and regs_o = 0; both FSMs in IDLE; held flags cleared.
- First cycle after reset release: awready=wready=arready=1.
- Read latency: AR handshake at edge N → rvalid=1 from edge N until the edge where rready is sampled high; minimum 1 cycle from handshake to response.
- Write latency:
  - The last of the AW/W handshakes completes at edge N; the register updates at edge N.
  - regs_o shows the new value, and bvalid=1, in the cycle after edge N.
- Back-to-back: with bready or rready held high, a new address is accepted the cycle after the response handshake. Maximum throughput is one transaction per 2 cycles per direction.
- Reset mid-transaction: all valids drop asynchronously and any pending write is discarded; nothing is committed after reset assertion.

## Configuration
- AXI4L_REGFILE_PROT_EN:
  - Defined: an access with prot[0]=0 (unprivileged) is rejected with SLVERR. Writes are suppressed and reads return 0. awprot is latched with AW.
  - Undefined: awprot and arprot are ignored; only the range check produces SLVERR.

## Structure
- axi4_types package holds the resp enum (OKAY=2'b00, SLVERR=2'b10) and the wr_state_t and rd_state_t enums.
- Sub-module axi4l_reg_bank holds the storage array, byte-strobe write port, combinational read port and flat regs_o. axi4l_regfile_slave holds the two FSMs, the holding registers and the decode/error logic.

## Test plan
- Write addr 0x04, data 0xDEADBEEF, wstrb 4'hF, AW and W in the same cycle → bvalid one cycle later, bresp=OKAY, regs_o reg1=0xDEADBEEF. Read 0x04 → rdata=0xDEADBEEF, rresp=OKAY.
- W sent 3 cycles before AW (addr 0x08, data 0x11223344, wstrb 4'b0101) on a register preset to 0xFFFFFFFF → reg2=0xFF22FF44, single bvalid pulse.
- Out-of-range: write and read at addr 0x3FC with NUM_REGS=16 → both return SLVERR, rdata=0, no register changes.
- Backpressure: hold rready=0 for 5 cycles after rvalid → rdata/rresp stable and arready=0 throughout. Same check for bready and bresp.
- Same-cycle read and write commit to reg3 (old 0x0, new 0xA5A5A5A5) → read returns 0x0; a subsequent read returns 0xA5A5A5A5.
- Assert ARESETn low while bvalid=1 → bvalid=0 immediately and all registers=0. With AXI4L_REGFILE_PROT_EN defined, a write with awprot=3'b000 → SLVERR and the register is unchanged.

Source files
------------

// File: rtl/axi4_types.sv
// axi4_types: shared AXI4-Lite response encodings and FSM state types.
package axi4_types;
   typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} resp_t;
   typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
   typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;
endpackage

// File: rtl/axi4_lite_if.sv
// axi4_lite_if: AXI4-Lite channel bundle with master/slave views.
interface axi4_lite_if #(
   parameter int ADDR_SIZE = 10,
   parameter int DATA_SIZE = 32
) (
   input logic ACLK,
   input logic ARESETn
);
   logic                   awvalid, awready;
   logic [ADDR_SIZE-1:0]   awaddr;
   logic [2:0]             awprot;
   logic                   wvalid, wready;
   logic [DATA_SIZE-1:0]   wdata;
   logic [DATA_SIZE/8-1:0] wstrb;
   logic                   bvalid, bready;
   logic [1:0]             bresp;
   logic                   arvalid, arready;
   logic [ADDR_SIZE-1:0]   araddr;
   logic [2:0]             arprot;
   logic                   rvalid, rready;
   logic [DATA_SIZE-1:0]   rdata;
   logic [1:0]             rresp;
   modport slave (
      input  ACLK, ARESETn, awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
   modport master (
      input  ACLK, ARESETn, awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready
   );
endinterface

// File: rtl/axi4l_reg_bank.sv
// axi4l_reg_bank: register storage with byte-strobe write port, async read port and flat export.
module axi4l_reg_bank #(
   parameter int DATA_SIZE = 32,
   parameter int NUM_REGS  = 16,
   parameter int IDX_W     = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_we,
   input  logic [IDX_W-1:0]              i_wr_idx,
   input  logic [DATA_SIZE-1:0]          i_wdata,
   input  logic [DATA_SIZE/8-1:0]        i_wstrb,
   input  logic [IDX_W-1:0]              i_rd_idx,
   output logic [DATA_SIZE-1:0]          o_rd_data,
   output logic [NUM_REGS*DATA_SIZE-1:0] o_regs
);
   logic [DATA_SIZE-1:0] r_mem [NUM_REGS];

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n)
         for (int k = 0; k < NUM_REGS; k++) r_mem[k] <= '0;
      else if (i_we)
         for (int j = 0; j < DATA_SIZE/8; j++)
            if (i_wstrb[j]) r_mem[i_wr_idx][j*8 +: 8] <= i_wdata[j*8 +: 8];

   assign o_rd_data = r_mem[i_rd_idx];

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
      assign o_regs[k*DATA_SIZE +: DATA_SIZE] = r_mem[k];
   end
endmodule

// File: rtl/axi4l_regfile_slave.sv
// axi4l_regfile_slave: AXI4-Lite register-file responder with independent read/write FSMs.
// Optional AXI4L_REGFILE_PROT_EN rejects unprivileged (prot[0]=0) accesses with SLVERR.
module axi4l_regfile_slave
   import axi4_types::*;
#(
   parameter int DATA_SIZE = 32,
   parameter int ADDR_SIZE = 10,
   parameter int NUM_REGS  = 16
) (
   axi4_lite_if.slave                     slv,
   output logic [NUM_REGS*DATA_SIZE-1:0]  regs_o
);
   localparam int IW = ADDR_SIZE - 2;
   localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int SW = DATA_SIZE / 8;

   wr_state_t            r_wr_st;
   rd_state_t            r_rd_st;
   logic                 r_aw_held, r_w_held;
   logic [IW-1:0]        r_aw_idx;
   logic [DATA_SIZE-1:0] r_wdata, r_rdata;
   logic [SW-1:0]        r_wstrb;
   resp_t                r_bresp, r_rresp;
   logic                 w_aw_hs, w_w_hs, w_commit, w_wr_err, w_rd_err, w_wr_oor, w_rd_oor;
   logic [IW-1:0]        w_wr_idx, w_rd_idx;
   logic [DATA_SIZE-1:0] w_wdata, w_bank_rdata;
   logic [SW-1:0]        w_wstrb;

   // Readies fall combinationally with reset so nothing is accepted while ARESETn is low.
   assign slv.awready = slv.ARESETn && r_wr_st == WR_IDLE && !r_aw_held;
   assign slv.wready  = slv.ARESETn && r_wr_st == WR_IDLE && !r_w_held;
   assign slv.arready = slv.ARESETn && r_rd_st == RD_IDLE;
   assign slv.bvalid  = r_wr_st == WR_RESP;
   assign slv.rvalid  = r_rd_st == RD_RESP;
   assign slv.bresp   = r_bresp;
   assign slv.rresp   = r_rresp;
   assign slv.rdata   = r_rdata;

   assign w_aw_hs  = slv.awvalid && slv.awready;
   assign w_w_hs   = slv.wvalid && slv.wready;
   assign w_wr_idx = r_aw_held ? r_aw_idx : slv.awaddr[ADDR_SIZE-1:2];
   assign w_wdata  = r_w_held ? r_wdata : slv.wdata;
   assign w_wstrb  = r_w_held ? r_wstrb : slv.wstrb;
   assign w_rd_idx = slv.araddr[ADDR_SIZE-1:2];
   assign w_commit = r_wr_st == WR_IDLE && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
   assign w_wr_oor = 32'(w_wr_idx) >= 32'(NUM_REGS);
   assign w_rd_oor = 32'(w_rd_idx) >= 32'(NUM_REGS);

`ifdef AXI4L_REGFILE_PROT_EN
   logic r_aw_priv;
   always_ff @(posedge slv.ACLK or negedge slv.ARESETn)
      if (!slv.ARESETn) r_aw_priv <= 1'b0;
      else if (w_aw_hs) r_aw_priv <= slv.awprot[0];
   assign w_wr_err = w_wr_oor || !(r_aw_held ? r_aw_priv : slv.awprot[0]);
   assign w_rd_err = w_rd_oor || !slv.arprot[0];
`else
   assign w_wr_err = w_wr_oor;
   assign w_rd_err = w_rd_oor;
`endif

   always_ff @(posedge slv.ACLK or negedge slv.ARESETn)
      if (!slv.ARESETn) begin
         r_wr_st   <= WR_IDLE;
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_aw_idx  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_bresp   <= OKAY;
      end else if (r_wr_st == WR_IDLE) begin
         if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_aw_idx  <= slv.awaddr[ADDR_SIZE-1:2];
         end
         if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= slv.wdata;
            r_wstrb  <= slv.wstrb;
         end
         if (w_commit) begin
            r_wr_st <= WR_RESP;
            r_bresp <= w_wr_err ? SLVERR : OKAY;
         end
      end else if (slv.bready) begin
         r_wr_st   <= WR_IDLE;
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
      end

   // rdata is captured from the bank before any same-edge commit lands, giving pre-write data.
   always_ff @(posedge slv.ACLK or negedge slv.ARESETn)
      if (!slv.ARESETn) begin
         r_rd_st <= RD_IDLE;
         r_rdata <= '0;
         r_rresp <= OKAY;
      end else if (r_rd_st == RD_IDLE) begin
         if (slv.arvalid) begin
            r_rd_st <= RD_RESP;
            r_rdata <= w_rd_err ? '0 : w_bank_rdata;
            r_rresp <= w_rd_err ? SLVERR : OKAY;
         end
      end else if (slv.rready) begin
         r_rd_st <= RD_IDLE;
      end

   axi4l_reg_bank #(
      .DATA_SIZE (DATA_SIZE),
      .NUM_REGS  (NUM_REGS),
      .IDX_W     (RW)
   ) u_bank (
      .i_clk     (slv.ACLK),
      .i_rst_n   (slv.ARESETn),
      .i_we      (w_commit && !w_wr_err),
      .i_wr_idx  (w_wr_idx[RW-1:0]),
      .i_wdata   (w_wdata),
      .i_wstrb   (w_wstrb),
      .i_rd_idx  (w_rd_idx[RW-1:0]),
      .o_rd_data (w_bank_rdata),
      .o_regs    (regs_o)
   );
endmodule
